memory_request_unit: RTL and testbench
======================================

MEMORY_REQUEST_UNIT -- requirements
Module: memory_request_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port CLK  in  1  system clock; all state updates on its rising edge.
REQ-003 Port RST  in  1  reset, synchronous to CLK, active-high.
REQ-004 Port dREN  in  1  current instruction is a load, from the control unit.
REQ-005 Port dWEN  in  1  current instruction is a store, from the control unit.
REQ-006 Port halt  in  1  current instruction is HALT, from the control unit.
REQ-007 Port ihit  in  1  instruction memory read complete.
REQ-008 Port dhit  in  1  data memory access complete.
REQ-009 Port imemREN  out  1  instruction read request.
REQ-010 Port dmemREN  out  1  data read request.
REQ-011 Port dmemWEN  out  1  data write request.
REQ-012 Port pc_en  out  1  one-cycle pulse: instruction retired, PC may advance.
REQ-013 Port halted  out  1  processor halted; sticky until RST.
REQ-014 Port instr_count  out  32  retired-instruction count.
REQ-015 Port mem_err  out  1  memory timeout error; sticky until RST.

Function
REQ-016 The FSM SHALL have exactly three states: FETCH, DATA, HALTED.
REQ-017 In FETCH: imemREN=1, dmemREN=0, dmemWEN=0; dhit ignored.
REQ-018 In FETCH with ihit=1 and halt=1, the next state SHALL be HALTED and pc_en=0.
REQ-019 In FETCH with ihit=1, halt=0, and dREN or dWEN set, the next state SHALL be DATA; the access type is latched that edge.
REQ-020 If dREN and dWEN are both set at latch time, the write SHALL win and dmemREN stays 0.
REQ-021 In FETCH with ihit=1, halt=0, dREN=0, dWEN=0: pc_en=1 combinationally that cycle; state stays FETCH.
REQ-022 In DATA: imemREN=0, and exactly one of dmemREN/dmemWEN=1 per the latched type; ihit ignored.
REQ-023 In DATA with dhit=1: pc_en=1 that cycle, and the next state SHALL be FETCH with dmem requests deasserted the next cycle.
REQ-024 The latched access type SHALL NOT change while in DATA, regardless of dREN/dWEN changes.
REQ-025 In HALTED: all requests=0, pc_en=0, halted=1; the only exit is RST.
REQ-026 halted SHALL be registered: 1 from the first cycle in HALTED.
REQ-027 instr_count SHALL increment by 1 on every edge where pc_en=1; 32'hFFFFFFFF wraps to 0.
REQ-028 pc_en SHALL never be high for two consecutive cycles in a data-access instruction, and SHALL be high for at most one cycle per instruction.

Reset
REQ-029 With RST=1 at an edge: state=FETCH, latched type cleared, instr_count=0, halted=0, mem_err=0, timeout counter=0.
REQ-030 The first cycle after reset SHALL show imemREN=1, dmemREN=0, dmemWEN=0, pc_en=0.
REQ-031 RST asserted mid-DATA or in HALTED SHALL override all other inputs that edge.

Configuration
REQ-032 Macro MEM_REQ_TIMEOUT_EN: when defined, an 8-bit counter SHALL count consecutive cycles in FETCH without ihit, or in DATA without dhit.
REQ-033 With MEM_REQ_TIMEOUT_EN, the counter SHALL clear on state change or on a hit.
REQ-034 With MEM_REQ_TIMEOUT_EN, on the edge where the counter reaches 255, mem_err SHALL be set to 1 and the next state SHALL be HALTED.
REQ-035 Without MEM_REQ_TIMEOUT_EN: no counter, mem_err is tied to 0, and the block waits indefinitely for a hit.

Verification
REQ-036 ALU instruction: RST then ihit=1 for 1 cycle, dREN=dWEN=halt=0 -> pc_en=1 that cycle, instr_count=1, imemREN stays 1.
REQ-037 Load: ihit=1 with dREN=1, then dhit after 3 cycles -> dmemREN=1 for 4 cycles, imemREN=0 meanwhile, pc_en once, instr_count+1.
REQ-038 Store with dREN=dWEN=1: ihit -> dmemWEN=1, dmemREN=0 until dhit; changing dWEN to 0 mid-DATA has no effect.
REQ-039 Halt: ihit=1 with halt=1 -> halted=1 next cycle, all requests 0 for 100 further cycles despite ihit/dhit toggling; RST returns to FETCH.
REQ-040 Timeout (MEM_REQ_TIMEOUT_EN defined): dmemREN held with no dhit -> mem_err=1 and halted=1 after 255 cycles; without the macro, mem_err stays 0 after 1000 cycles.

Source files
------------

// File: rtl/memory_request_unit.sv
// memory_request_unit: sequences instruction fetch and data access requests
// for a single-issue core, pulses pc_en once per retired instruction and
// counts retired instructions.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   dREN, dWEN, halt    decoded class of the current instruction
//   ihit, dhit          instruction / data memory access complete
//   imemREN             instruction read request (combinational)
//   dmemREN, dmemWEN    data read / write request (combinational)
//   pc_en               instruction retired this cycle (combinational)
//   halted              processor halted, sticky until RST (registered)
//   instr_count         retired-instruction count, wraps at 2^32
//   mem_err             memory timeout error, sticky until RST
//
// Optional feature: define MEM_REQ_TIMEOUT_EN to halt with mem_err after
// 255 consecutive cycles waiting on a memory hit. Without it mem_err is 0
// and the unit waits indefinitely.
module memory_request_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        halt,
   input  logic        ihit,
   input  logic        dhit,
   output logic        imemREN,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic        pc_en,
   output logic        halted,
   output logic [31:0] instr_count,
   output logic        mem_err
);

   localparam int unsigned COUNT_W = 32;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state, state_next;
   logic   wr_q, wr_next;      // latched access type: 1 = store, 0 = load
   logic   timeout_c;          // wait budget exhausted this cycle

   // Next-state and request decode
   always_comb begin
      state_next = state;
      wr_next    = wr_q;
      imemREN    = 1'b0;
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      pc_en      = 1'b0;
      case (state)
         FETCH: begin
            imemREN = 1'b1;
            if (ihit) begin
               if (halt) begin
                  state_next = HALTED;
               end else if (dREN || dWEN) begin
                  state_next = DATA;
                  wr_next    = dWEN;   // store wins when both are set
               end else begin
                  pc_en = 1'b1;
               end
            end
         end
         DATA: begin
            dmemREN = ~wr_q;
            dmemWEN = wr_q;
            if (dhit) begin
               pc_en      = 1'b1;
               state_next = FETCH;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
      if (timeout_c) begin
         state_next = HALTED;
      end
   end

   // State, access type and retire counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= FETCH;
         wr_q        <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= state_next;
         wr_q  <= wr_next;
         if (pc_en) begin
            instr_count <= instr_count + COUNT_W'(1);
         end
      end
   end

   // Halted flag is set on entry and only cleared by reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         halted <= 1'b0;
      end else if (state_next == HALTED) begin
         halted <= 1'b1;
      end
   end

`ifdef MEM_REQ_TIMEOUT_EN
   localparam int unsigned TIMEOUT_W = 8;
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(254);

   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 waiting_c;

   // A cycle is a waiting cycle when the pending access has not hit
   assign waiting_c = ((state == FETCH) && !ihit) || ((state == DATA) && !dhit);
   assign timeout_c = waiting_c && (wait_cnt == TIMEOUT_LAST);

   // Consecutive wait counter; any hit or state change restarts it
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (waiting_c) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (timeout_c) begin
            mem_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_c = 1'b0;
   assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_request_unit.sv
// Testbench for memory_request_unit: directed scenarios with literal
// expectations plus randomized traffic, all compared against an
// instruction-level reference model every cycle.
module tb_memory_request_unit;

   logic        CLK = 1'b0;
   logic        RST, dREN, dWEN, halt, ihit, dhit;
   logic        imemREN, dmemREN, dmemWEN, pc_en, halted, mem_err;
   logic [31:0] instr_count;

   int checks = 0;
   int failures = 0;

   // Reference model: where the current instruction is in its life
   bit          m_in_data;     // fetch done, data access outstanding
   bit          m_is_store;
   bit          m_halted;
   bit          m_err;
   logic [31:0] m_count;
   int          m_wait;        // consecutive cycles without the awaited hit

   // Last sampled DUT outputs
   logic        s_imem, s_dren, s_dwen, s_pc, s_halted, s_err;
   logic [31:0] s_count;

   memory_request_unit dut (
      .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .halt(halt),
      .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN),
      .dmemWEN(dmemWEN), .pc_en(pc_en), .halted(halted),
      .instr_count(instr_count), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_in_data  = 0;
      m_is_store = 0;
      m_halted   = 0;
      m_err      = 0;
      m_count    = 0;
      m_wait     = 0;
   endfunction

   function automatic bit exp_pc();
      if (m_halted) return 0;
      if (m_in_data) return dhit;
      return ihit && !halt && !dREN && !dWEN;
   endfunction

   // Advance the model by one clock using the inputs present at the edge
   function automatic void model_edge();
      bit hit;
      if (RST) begin
         model_reset();
         return;
      end
      if (m_halted) return;
      hit = m_in_data ? dhit : ihit;
      if (exp_pc()) m_count = m_count + 1;
      if (!m_in_data && ihit) begin
         if (halt) m_halted = 1;
         else if (dREN || dWEN) begin
            m_in_data  = 1;
            m_is_store = dWEN;
         end
      end else if (m_in_data && dhit) begin
         m_in_data = 0;
      end
`ifdef MEM_REQ_TIMEOUT_EN
      if (hit) m_wait = 0;
      else m_wait = m_wait + 1;
      if (m_wait == 255) begin
         m_halted  = 1;
         m_err     = 1;
         m_in_data = 0;
         m_wait    = 0;
      end
`else
      if (hit) m_wait = 0;
`endif
   endfunction

   // One cycle: drive, compare at the falling edge, then advance the model
   task automatic step(input logic rst, input logic dr, input logic dw,
                       input logic hl, input logic ih, input logic dh);
      RST = rst; dREN = dr; dWEN = dw; halt = hl; ihit = ih; dhit = dh;
      @(negedge CLK);
      s_imem = imemREN; s_dren = dmemREN; s_dwen = dmemWEN; s_pc = pc_en;
      s_halted = halted; s_err = mem_err; s_count = instr_count;
      check("imemREN", 32'(s_imem), 32'(!m_halted && !m_in_data));
      check("dmemREN", 32'(s_dren), 32'(!m_halted && m_in_data && !m_is_store));
      check("dmemWEN", 32'(s_dwen), 32'(!m_halted && m_in_data && m_is_store));
      check("pc_en", 32'(s_pc), 32'(exp_pc()));
      check("halted", 32'(s_halted), 32'(m_halted));
      check("mem_err", 32'(s_err), 32'(m_err));
      check("instr_count", s_count, m_count);
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int n_rd, n_pc, n_req, n_cyc;
      RST = 1; dREN = 0; dWEN = 0; halt = 0; ihit = 0; dhit = 0;
      @(posedge CLK);
      model_reset();
      #1;

      // Reset state
      step(1, 1, 1, 1, 0, 1);
      check("rst_imem", 32'(s_imem), 32'd1);
      check("rst_pc", 32'(s_pc), 32'd0);
      check("rst_count", s_count, 32'd0);

      // ALU instruction retires in the fetch cycle
      step(0, 0, 0, 0, 1, 0);
      check("alu_pc", 32'(s_pc), 32'd1);
      idle();
      check("alu_count", s_count, 32'd1);
      check("alu_imem", 32'(s_imem), 32'd1);

      // Load with dhit three cycles into the access
      step(0, 1, 0, 0, 1, 0);
      n_rd = 0; n_pc = 0; n_req = 0;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, (i == 3) ? 1'b1 : 1'b0);
         n_rd += int'(s_dren);
         n_pc += int'(s_pc);
         n_req += int'(s_imem);
      end
      check("load_dren_cycles", 32'(n_rd), 32'd4);
      check("load_pc_pulses", 32'(n_pc), 32'd1);
      check("load_imem_cycles", 32'(n_req), 32'd0);
      idle();
      check("load_count", s_count, 32'd2);
      check("load_dren_after", 32'(s_dren), 32'd0);

      // Store beats load; dropping dWEN mid-access changes nothing
      step(0, 1, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);
      check("store_dwen", 32'(s_dwen), 32'd1);
      check("store_dren", 32'(s_dren), 32'd0);
      step(0, 1, 0, 0, 0, 1);
      check("store_dwen_hit", 32'(s_dwen), 32'd1);
      check("store_pc", 32'(s_pc), 32'd1);

      // Halt is sticky across 100 cycles of memory activity
      step(0, 0, 0, 1, 1, 0);
      check("halt_pc", 32'(s_pc), 32'd0);
      n_req = 0;
      for (int i = 0; i < 100; i++) begin
         step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_req += int'(s_imem | s_dren | s_dwen | s_pc | !s_halted);
      end
      check("halt_quiet", 32'(n_req), 32'd0);
      step(1, 0, 0, 0, 1, 1);
      idle();
      check("halt_exit_imem", 32'(s_imem), 32'd1);
      check("halt_exit_halted", 32'(s_halted), 32'd0);
      check("halt_exit_count", s_count, 32'd0);

      // Data access that never completes
      step(0, 1, 0, 0, 1, 0);
      n_cyc = 0;
      for (int i = 0; i < 1000; i++) begin
         step(0, 1, 0, 0, 1, 0);
         if (!s_halted) n_cyc++;
      end
`ifdef MEM_REQ_TIMEOUT_EN
      check("timeout_wait_cycles", 32'(n_cyc), 32'd255);
      check("timeout_err", 32'(s_err), 32'd1);
      check("timeout_halted", 32'(s_halted), 32'd1);
`else
      check("no_timeout_cycles", 32'(n_cyc), 32'd1000);
      check("no_timeout_err", 32'(s_err), 32'd0);
      check("no_timeout_dren", 32'(s_dren), 32'd1);
`endif
      step(1, 0, 0, 0, 0, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 79) == 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 29) == 0),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
